// File: rtl/nco_pkg.sv
// nco_pkg: shared widths and sample-conditioning helpers for the NCO back end.
//   DATA_W_DEF / AMP_W_DEF : default sample and gain widths
//   offset_bin()           : two's complement -> offset binary (flip MSB)
//   amp_scale()            : (conv * (amp+1)) >> aw, never exceeds conv
// Helpers work on a generous fixed word so callers of any width up to MAX_W
// can share them; callers cast in and out at their own width.
package nco_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int AMP_W_DEF  = 4;
    localparam int MAX_W      = 16;
    localparam int PROD_W     = 2 * MAX_W + 1;

    typedef logic [MAX_W-1:0]  word_t;
    typedef logic [PROD_W-1:0] prod_t;

    // w is the live sample width; only bit w-1 is inverted.
    function automatic word_t offset_bin(input word_t s, input int unsigned w);
        return s ^ (word_t'(1) << (w - 1));
    endfunction

    // amp+1 ranges 1..2^aw, so the shifted product is at most conv.
    function automatic word_t amp_scale(input word_t c, input word_t a, input int unsigned aw);
        prod_t p;
        p = prod_t'(c) * (prod_t'(a) + prod_t'(1));
        return word_t'(p >> aw);
    endfunction

endpackage

// File: rtl/nco_dead_time.sv
// nco_dead_time: turns the raw PWM level into complementary gate drives with
// a dead band after every transition.
//   clk, rst      : clock, async active-low reset
//   raw           : registered raw PWM level
//   running       : modulator running (already qualified with enable)
//   pwm_out       : high-side drive, registered
//   pwm_out_n     : low-side drive, registered
// A raw edge, or the start of running, loads DEAD into the counter; a side
// only drives once the counter has drained, so pulses of DEAD clocks or
// fewer are swallowed and the two sides can never overlap.
module nco_dead_time
    import nco_pkg::*;
#(
    parameter int DEAD = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    input  logic running,
    output logic pwm_out,
    output logic pwm_out_n
);

    localparam int CW = 4;

    logic          raw_prev_q, run_prev_q;
    logic [CW-1:0] dead_q, dead_d;
    logic          pwm_q, pwm_d, pwm_n_q, pwm_n_d;
    logic          chg;

    always_comb begin
        // Run start counts as an edge so the low side also waits out the band.
        chg    = (raw != raw_prev_q) | (running & ~run_prev_q);
        dead_d = '0;
        if (running) begin
            if (chg)
                dead_d = CW'(DEAD);
            else if (dead_q != '0)
                dead_d = dead_q - CW'(1);
        end
        pwm_d   = running &  raw & (dead_d == '0);
        pwm_n_d = running & ~raw & (dead_d == '0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            raw_prev_q <= 1'b0;
            run_prev_q <= 1'b0;
            dead_q     <= '0;
            pwm_q      <= 1'b0;
            pwm_n_q    <= 1'b0;
        end else begin
            raw_prev_q <= raw;
            run_prev_q <= running;
            dead_q     <= dead_d;
            pwm_q      <= pwm_d;
            pwm_n_q    <= pwm_n_d;
        end
    end

    assign pwm_out   = pwm_q;
    assign pwm_out_n = pwm_n_q;

endmodule

// File: rtl/nco_pwm_dac.sv
// nco_pwm_dac: PWM DAC stage fed by the NCO sample stream.
//   clk, rst        : clock, async active-low reset
//   en              : run enable
//   sample/_valid   : incoming sample and its valid
//   sample_ready    : holding register can take a sample this cycle
//   signed_in, amp  : sample format and gain, captured at accept
//   clr_underrun    : clears the sticky underrun flag
//   pwm_out(_n)     : complementary PWM drives with dead time
//   period_start    : pulse on the first clock of each PWM period
//   underrun        : sticky, a period began without a fresh sample
// Each accepted sample is scaled and parked in hold; at every period
// boundary (tick) hold moves into duty, and one period of 2^DATA_W clocks
// renders it. Without a fresh sample the old duty is replayed.
module nco_pwm_dac
    import nco_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int AMP_W  = AMP_W_DEF,
    parameter int DEAD   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [DATA_W-1:0] sample,
    input  logic              sample_valid,
    output logic              sample_ready,
    input  logic              signed_in,
    input  logic [AMP_W-1:0]  amp,
    input  logic              clr_underrun,
    output logic              pwm_out,
    output logic              pwm_out_n,
    output logic              period_start,
    output logic              underrun
);

    logic [DATA_W-1:0] cnt_q, cnt_d, duty_q, duty_d, hold_q, hold_d;
    logic [DATA_W-1:0] conv, scaled;
    logic              hold_full_q, hold_full_d, running_q, running_d;
    logic              raw_q, raw_d, ps_q, und_q, und_d;
    logic              tick, accept, run_en;

    assign tick         = en & (~running_q | (cnt_q == '1));
    // A tick frees hold in the same cycle, so a back-to-back sample is never stalled.
    assign sample_ready = ~hold_full_q | tick;
    assign accept       = sample_valid & sample_ready;
    assign run_en       = running_q & en;

    assign conv   = signed_in ? DATA_W'(offset_bin(word_t'(sample), DATA_W)) : sample;
    assign scaled = DATA_W'(amp_scale(word_t'(conv), word_t'(amp), AMP_W));

    always_comb begin
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        duty_d      = duty_q;
        und_d       = und_q;
        running_d   = running_q;
        cnt_d       = cnt_q;

        if (tick && hold_full_q) begin
            duty_d      = hold_q;
            hold_full_d = 1'b0;
        end

        // A fresh underrun beats a coincident clear.
        if (tick && !hold_full_q && running_q)
            und_d = 1'b1;
        else if (clr_underrun)
            und_d = 1'b0;

        // Placed after the tick load so a same-cycle accept refills hold.
        if (accept) begin
            hold_d      = scaled;
            hold_full_d = 1'b1;
        end

        if (!en) begin
            running_d = 1'b0;
            cnt_d     = '0;
        end else if (tick) begin
            running_d = 1'b1;
            cnt_d     = '0;
        end else if (running_q) begin
            cnt_d = cnt_q + DATA_W'(1);
        end

        raw_d = run_en & (cnt_q < duty_q);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q       <= '0;
            duty_q      <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            running_q   <= 1'b0;
            raw_q       <= 1'b0;
            ps_q        <= 1'b0;
            und_q       <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            duty_q      <= duty_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            running_q   <= running_d;
            raw_q       <= raw_d;
            ps_q        <= tick;
            und_q       <= und_d;
        end
    end

    assign period_start = ps_q;
    assign underrun     = und_q;

    nco_dead_time #(.DEAD(DEAD)) u_dead (
        .clk      (clk),
        .rst      (rst),
        .raw      (raw_q),
        .running  (run_en),
        .pwm_out  (pwm_out),
        .pwm_out_n(pwm_out_n)
    );

endmodule

// File: tb/tb_nco_pwm_dac.sv
// tb_nco_pwm_dac: drives a per-period plan (directed periods then random
// ones) and checks each PWM period against pulse-length arithmetic on the
// duty sequence the bench derives itself from the samples it sent.
module tb_nco_pwm_dac;

    localparam int DEAD   = 2;
    localparam int NPER   = 42;
    localparam int BUDGET = (NPER + 3) * 256;

    logic       clk, rst, en, sample_valid, signed_in, clr_underrun;
    logic [7:0] sample;
    logic [3:0] amp;
    logic       sample_ready, pwm_out, pwm_out_n, period_start, underrun;

    nco_pwm_dac #(.DATA_W(8), .AMP_W(4), .DEAD(DEAD)) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .sample      (sample),
        .sample_valid(sample_valid),
        .sample_ready(sample_ready),
        .signed_in   (signed_in),
        .amp         (amp),
        .clr_underrun(clr_underrun),
        .pwm_out     (pwm_out),
        .pwm_out_n   (pwm_out_n),
        .period_start(period_start),
        .underrun    (underrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Reference gain stage straight from the arithmetic definition.
    function automatic int ref_scale(input int s, input int sgn, input int a);
        int c;
        c = sgn ? (s ^ 128) : s;
        return (c * (a + 1)) >> 4;
    endfunction

    // Window of a period = raw positions 1..256 relative to its period_start
    // (position 256 is the next period's first clock, always low). A drive is
    // on where its raw level has already persisted for more than DEAD clocks.
    function automatic int exp_hi(input int d);
        int n = 0;
        for (int r = 1; r <= 256; r++)
            if (r <= d && r > DEAD) n++;
        return n;
    endfunction

    function automatic int exp_lo(input int d, input int dp);
        int n = 0;
        int ls;
        if (d > 0)       ls = d + 1;
        else if (dp > 0) ls = dp + 1 - 256;
        else if (dp == 0) ls = -1000;
        else             ls = 0;
        for (int r = 1; r <= 256; r++)
            if (r > d && (r - ls + 1) > DEAD) n++;
        return n;
    endfunction

    int p_mode[NPER], p_smp[NPER], p_sgn[NPER], p_amp[NPER], p_lsmp[NPER], p_clr[NPER];
    int duty[NPER+1];

    task automatic plan(input int k, input int m, input int s, input int sg, input int a,
                        input int ls, input int c);
        p_mode[k] = m; p_smp[k] = s; p_sgn[k] = sg; p_amp[k] = a; p_lsmp[k] = ls; p_clr[k] = c;
    endtask

    task automatic drive(input int s, input int sg, input int a);
        sample = 8'(s); signed_in = sg[0]; amp = 4'(a); sample_valid = 1'b1;
    endtask

    initial begin
        int k, pos, since, pend, pend_v, late, late_v, und_exp, done;
        int acc_hi, acc_lo, acc_ov, quiet, found;

        rst = 1'b0; en = 1'b0; sample_valid = 1'b0; clr_underrun = 1'b0;
        sample = '0; signed_in = 1'b0; amp = '0;

        // mode 0 skip, 1 deliver at pos 10, 2 also deliver late at pos 255
        plan(0,  1, 8'h80, 0, 15, 0, -1);
        plan(1,  1, 8'h00, 1, 7,  0, -1);
        plan(2,  0, 0, 0, 0, 0, -1);
        plan(3,  0, 0, 0, 0, 0, 255);
        plan(4,  1, 8'hFF, 0, 15, 0, 20);
        plan(5,  1, 8'hFF, 0, 15, 0, -1);
        plan(6,  1, 8'h00, 0, 15, 0, -1);
        plan(7,  1, 8'h00, 0, 15, 0, -1);
        plan(8,  1, 8'h00, 0, 15, 0, -1);
        plan(9,  2, 8'hC0, 0, 15, 8'h20, -1);
        plan(10, 0, 0, 0, 0, 0, -1);
        plan(11, 1, 8'h80, 0, 15, 0, -1);
        for (int i = 12; i < NPER; i++)
            plan(i, ($urandom_range(0, 4) == 0) ? 0 : 1, int'($urandom_range(0, 255)),
                 int'($urandom_range(0, 1)), int'($urandom_range(0, 15)), 0,
                 ($urandom_range(0, 5) == 0) ? int'($urandom_range(5, 255)) : -1);

        repeat (3) @(negedge clk);
        chk("rst_pwm", pwm_out, 0);
        chk("rst_pwm_n", pwm_out_n, 0);
        chk("rst_ps", period_start, 0);
        chk("rst_und", underrun, 0);
        chk("rst_rdy", sample_ready, 1);
        rst = 1'b1;

        // Preload the first sample while idle; handshake runs without en.
        @(negedge clk);
        chk("idle_rdy", sample_ready, 1);
        drive(8'h80, 0, 15);
        pend = ref_scale(8'h80, 0, 15); pend_v = 1;
        @(negedge clk);
        sample_valid = 1'b0;
        chk("idle_full_rdy", sample_ready, 0);
        chk("idle_pwm", pwm_out, 0);
        en = 1'b1;

        k = -1; pos = -1; since = 0; late = 0; late_v = 0; und_exp = 0; done = 0;
        acc_hi = 0; acc_lo = 0; acc_ov = 0;
        for (int cyc = 0; cyc < BUDGET; cyc++) begin
            @(negedge clk);
            sample_valid = 1'b0; clr_underrun = 1'b0;
            since++;
            if (period_start) begin
                if (k >= 0) chk("ps_gap", since, 256);
                since = 0; k++; pos = 0;
                if (pend_v) duty[k] = pend;
                else if (k > 0) begin duty[k] = duty[k-1]; und_exp = 1; end
                pend_v = late_v; pend = late; late_v = 0;
                if (k == NPER) begin done = 1; break; end
            end else if (pos >= 0) pos++;

            if (pos == 2) begin
                if (k >= 1) begin
                    chk($sformatf("hi_cnt p%0d", k-1), acc_hi, exp_hi(duty[k-1]));
                    chk($sformatf("lo_cnt p%0d", k-1), acc_lo,
                        exp_lo(duty[k-1], (k >= 2) ? duty[k-2] : -1));
                    chk($sformatf("overlap p%0d", k-1), acc_ov, 0);
                end
                acc_hi = 0; acc_lo = 0; acc_ov = 0;
            end
            acc_hi += int'(pwm_out);
            acc_lo += int'(pwm_out_n);
            acc_ov += int'(pwm_out & pwm_out_n);

            if (pos == 3) chk($sformatf("underrun p%0d", k), underrun, und_exp);

            if (k >= 0) begin
                if (pos == 10 && p_mode[k] != 0) begin
                    chk("rdy_accept", sample_ready, 1);
                    drive(p_smp[k], p_sgn[k], p_amp[k]);
                    pend = ref_scale(p_smp[k], p_sgn[k], p_amp[k]); pend_v = 1;
                end
                if (p_mode[k] == 2 && pos == 254) chk("rdy_full", sample_ready, 0);
                if (p_mode[k] == 2 && pos == 255) begin
                    chk("rdy_tick", sample_ready, 1);
                    drive(p_lsmp[k], 0, 15);
                    late = ref_scale(p_lsmp[k], 0, 15); late_v = 1;
                end
                if (pos == p_clr[k]) begin clr_underrun = 1'b1; und_exp = 0; end
            end
        end
        if (!done) chk("period_timeout", k, NPER);

        // en low: both drives and period_start must go quiet.
        sample_valid = 1'b0; clr_underrun = 1'b0; en = 1'b0;
        quiet = 0;
        repeat (20) begin
            @(negedge clk);
            quiet += int'(pwm_out | pwm_out_n | period_start);
        end
        chk("en0_quiet", quiet, 0);

        // Full-scale sample so pwm_out is high, then reset mid-period.
        chk("en0_rdy", sample_ready, 1);
        drive(8'hFF, 0, 15);
        @(negedge clk);
        sample_valid = 1'b0; en = 1'b1;
        found = 0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (pwm_out) begin found = 1; break; end
        end
        chk("pwm_hi_wait", found, 1);
        #2 rst = 1'b0; en = 1'b0;
        #1;
        chk("mid_rst_pwm", pwm_out, 0);
        chk("mid_rst_pwm_n", pwm_out_n, 0);
        chk("mid_rst_ps", period_start, 0);
        chk("mid_rst_und", underrun, 0);
        chk("mid_rst_rdy", sample_ready, 1);
        @(negedge clk);
        rst = 1'b1;
        quiet = 0;
        repeat (300) begin
            @(negedge clk);
            quiet += int'(pwm_out | pwm_out_n | period_start);
        end
        chk("post_rst_quiet", quiet, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
